param_updown_counter: RTL

PARAM_UPDOWN_COUNTER -- requirements
Module: param_updown_counter

---
 rtl/param_updown_counter_pkg.sv | 15 +
 rtl/tick_gen.sv | 34 +++
 rtl/param_updown_counter.sv | 89 ++++++++
 3 files changed

// File: rtl/param_updown_counter_pkg.sv
// Shared constants and helpers for the parameterised up/down counter.
// Holds the boundary-mode encodings and the prescaler width calculation.
package param_updown_counter_pkg;

    localparam int MODE_WRAP = 0;
    localparam int MODE_SAT  = 1;

    // A single-cycle prescaler still needs a one-bit register to stay legal.
    function automatic int prescale_width(input int prescale);
        int w;
        w = $clog2(prescale);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/tick_gen.sv
// Prescaler: emits tick once every PRESCALE enabled cycles.
// The clr input discards any partial count.
module tick_gen
    import param_updown_counter_pkg::*;
#(
    parameter int PRESCALE = 1
) (
    input  logic cl,
    input  logic r,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int PW = prescale_width(PRESCALE);
    localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] r_count;
    logic          w_last;

    assign w_last = (r_count == LAST);
    assign tick   = en && w_last;

    always_ff @(posedge cl or posedge r) begin
        if (r) begin
            r_count <= '0;
        end else if (clr) begin
            r_count <= '0;
        end else if (en) begin
            r_count <= w_last ? '0 : r_count + PW'(1);
        end
    end

endmodule

// File: rtl/param_updown_counter.sv
// Up/down counter with terminal count MAX, wrap or saturate mode,
// prescaled stepping, synchronous load, terminal pulse and sticky overflow.
module param_updown_counter
    import param_updown_counter_pkg::*;
#(
    parameter int WIDTH    = 3,
    parameter int MAX      = 2**WIDTH - 1,
    parameter int SAT      = MODE_WRAP,
    parameter int PRESCALE = 1
) (
    input  logic             cl,
    input  logic             r,
    input  logic             en,
    input  logic             up,
    input  logic             ld,
    input  logic [WIDTH-1:0] ld_val,
    input  logic             ovf_clr,
    output logic [WIDTH-1:0] c0,
    output logic             tc,
    output logic             ovf
);

    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

    logic [WIDTH-1:0] r_count;
    logic             r_tc;
    logic             r_ovf;
    logic [WIDTH-1:0] w_next;
    logic [WIDTH-1:0] w_load;
    logic             w_tick;
    logic             w_boundary;

    tick_gen #(
        .PRESCALE(PRESCALE)
    ) u_tick_gen (
        .cl   (cl),
        .r    (r),
        .en   (en),
        .clr  (ld),
        .tick (w_tick)
    );

    assign w_load = (ld_val > MAX_V) ? MAX_V : ld_val;

    // A load pre-empts any step, so a boundary can only arise when ld is low.
    always_comb begin
        w_next     = r_count;
        w_boundary = 1'b0;
        if (w_tick && !ld) begin
            if (up) begin
                if (r_count == MAX_V) begin
                    w_boundary = 1'b1;
                    w_next     = (SAT == MODE_SAT) ? MAX_V : '0;
                end else begin
                    w_next = r_count + WIDTH'(1);
                end
            end else begin
                if (r_count == '0) begin
                    w_boundary = 1'b1;
                    w_next     = (SAT == MODE_SAT) ? '0 : MAX_V;
                end else begin
                    w_next = r_count - WIDTH'(1);
                end
            end
        end
    end

    always_ff @(posedge cl or posedge r) begin
        if (r) begin
            r_count <= '0;
            r_tc    <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            r_count <= ld ? w_load : w_next;
            r_tc    <= w_boundary;
            // Setting wins over clearing when both happen together.
            if (w_boundary) begin
                r_ovf <= 1'b1;
            end else if (ovf_clr) begin
                r_ovf <= 1'b0;
            end
        end
    end

    assign c0  = r_count;
    assign tc  = r_tc;
    assign ovf = r_ovf;

endmodule
